encoder_speed: RTL and testbench
================================

ENCODER_SPEED -- requirements
Module: encoder_speed

Interface
REQ-001 The block SHALL provide parameter SAMPLE_DIV, default 10000, meaning clock cycles per speed sample window (legal range 2..65535).
REQ-002 The block SHALL provide port iClk  input  1  system clock; all logic rising-edge triggered.
REQ-003 The block SHALL provide port iRst_n  input  1  reset: asynchronous, active-low.
REQ-004 The block SHALL provide port iEn  input  1  measurement enable (high = windows run).
REQ-005 The block SHALL provide port iEnc_A  input  1  encoder channel A, asynchronous to iClk.
REQ-006 The block SHALL provide port iEnc_B  input  1  encoder channel B, asynchronous to iClk.
REQ-007 The block SHALL provide port oSpd_coder  output  13  signed speed, counts per window, feeds speed-loop iSpd_coder.
REQ-008 The block SHALL provide port oSpd_valid  output  1  one-cycle strobe, new oSpd_coder value, feeds speed-loop iSL_en.
REQ-009 The block SHALL provide port oPos  output  16  unsigned position count, wraps modulo 65536.
REQ-010 The block SHALL provide port oEnc_err  output  1  sticky illegal-transition flag.

Function
REQ-011 The block SHALL pass A and B each through a 2-flop synchronizer followed by one history register; decode compares history (prev) with synchronized value (cur).
REQ-012 The decoder SHALL produce +1 for prev->cur in 00->01, 01->11, 11->10, 10->00; -1 for the reverse of each; 0 for no change.
REQ-013 A transition changing both bits SHALL produce 0 and set oEnc_err; oEnc_err SHALL stay set until reset or iEn low.
REQ-014 oPos SHALL add the decoded step every cycle, regardless of iEn, wrapping 65535->0 and 0->65535; a pin change SHALL be visible on oPos exactly 3 clocks later.
REQ-015 While iEn high, a window counter SHALL count 0..SAMPLE_DIV-1 and wrap; a 16-bit signed window accumulator SHALL add each decoded step, saturating at -32768/+32767.
REQ-016 On the cycle the window counter equals SAMPLE_DIV-1, the block SHALL register the final accumulator value (including that cycle's step) as the window delta.
REQ-017 oSpd_coder SHALL be the window delta saturated to -4096..+4095 and SHALL update, together with a single-cycle oSpd_valid pulse, one clock after REQ-016.
REQ-018 The accumulator SHALL restart at 0 after a terminal cycle; a step decoded in the cycle after terminal SHALL belong to the new window (no count lost or double-counted).
REQ-019 While iEn low: window counter and accumulator held at 0, oSpd_valid 0, oSpd_coder holds last value, oEnc_err cleared.
REQ-020 On iEn rising, the first window SHALL start at counter 0 and produce its first oSpd_valid SAMPLE_DIV+1 clocks after iEn is sampled high.

Reset
REQ-021 On iRst_n low, all synchronizer/history flops, counters, accumulator, oSpd_coder, oPos, oSpd_valid, oEnc_err SHALL go to 0 immediately; synchronizer history loads 0 so the first sampled non-00 state after reset SHALL decode per REQ-012/013.
REQ-022 Reset asserted mid-window SHALL discard the partial window; no oSpd_valid SHALL be issued for it.

Configuration
REQ-023 With macro ENCODER_SPEED_FILTER_EN defined, oSpd_coder SHALL be the sum of the last 4 saturated window deltas arithmetic-shifted right by 2 (truncation toward -inf), history cleared to 0 by reset and by iEn low; oSpd_valid timing unchanged.
REQ-024 Without ENCODER_SPEED_FILTER_EN, oSpd_coder SHALL be the raw saturated window delta per REQ-017 and no filter storage SHALL be synthesized.

Verification (SAMPLE_DIV=100 unless stated)
REQ-025 Forward quadrature, one state step every 10 clocks, iEn=1 -> oSpd_coder=+10 on every oSpd_valid, pulses exactly 100 clocks apart, oPos increments 10 per window.
REQ-026 Reverse quadrature, one step every 5 clocks -> oSpd_coder=-20; oPos decrements from 0 wraps to 65535 on first step.
REQ-027 AB forced 00->11 -> oEnc_err=1 3 clocks later, oPos unchanged; drive iEn low one clock -> oEnc_err=0.
REQ-028 SAMPLE_DIV=10000, forward step every 2 clocks -> raw delta 5000, oSpd_coder=+4095.
REQ-029 iRst_n pulsed low at window counter 50 -> all outputs 0 immediately, no oSpd_valid until 100 clocks after release (plus latency).
REQ-030 ENCODER_SPEED_FILTER_EN defined, steps go from 0 to 8 per window -> successive oSpd_coder 2, 4, 6, 8; undefined -> 8, 8, 8, 8.

Source files
------------

// File: rtl/encoder_speed_if.sv
// encoder_speed_if
// Bundles the quadrature encoder inputs and the speed/position results of
// encoder_speed. Member names match the legacy flat port names so existing
// connections map one-to-one onto interface members.
//
// Members:
//   iEn        measurement enable (high = sample windows run)
//   iEnc_A     encoder channel A, asynchronous to the block clock
//   iEnc_B     encoder channel B, asynchronous to the block clock
//   oSpd_coder signed counts per window (13 bits), feeds speed-loop iSpd_coder
//   oSpd_valid one-cycle strobe marking a new oSpd_coder value
//   oPos       unsigned position count, wraps modulo 65536
//   oEnc_err   sticky illegal-transition flag
//
// Modports:
//   master  side that drives the encoder inputs and consumes results
//   slave   the encoder_speed block itself
interface encoder_speed_if;
    logic               iEn;
    logic               iEnc_A;
    logic               iEnc_B;
    logic signed [12:0] oSpd_coder;
    logic               oSpd_valid;
    logic        [15:0] oPos;
    logic               oEnc_err;

    modport master (
        output iEn, iEnc_A, iEnc_B,
        input  oSpd_coder, oSpd_valid, oPos, oEnc_err
    );

    modport slave (
        input  iEn, iEnc_A, iEnc_B,
        output oSpd_coder, oSpd_valid, oPos, oEnc_err
    );
endinterface

// File: rtl/encoder_speed.sv
// encoder_speed
// Quadrature encoder decoder with position counter and windowed speed
// measurement. A/B are synchronised (2 flops) plus one history flop; each
// cycle the history/current pair is decoded into a +1/-1/0 step. Position
// integrates every step. While enabled, steps are accumulated over windows of
// SAMPLE_DIV clocks; one clock after the terminal cycle the saturated window
// delta is presented on oSpd_coder with a one-cycle oSpd_valid strobe.
//
// Optional feature: define ENCODER_SPEED_FILTER_EN to output the mean of the
// last four saturated window deltas (sum >>> 2) instead of the raw delta.
//
// Parameters:
//   SAMPLE_DIV  clock cycles per speed window (2..65535)
// Ports:
//   iClk    system clock, rising edge
//   iRst_n  asynchronous active-low reset
//   bus     encoder_speed_if.slave (iEn, iEnc_A, iEnc_B, oSpd_coder,
//           oSpd_valid, oPos, oEnc_err)
module encoder_speed #(
    parameter int unsigned SAMPLE_DIV = 10000
) (
    input  logic           iClk,
    input  logic           iRst_n,
    encoder_speed_if.slave bus
);

    localparam logic [15:0] LAST_CNT = 16'(SAMPLE_DIV - 1);

    logic               a_s1, a_s2, a_prev;
    logic               b_s1, b_s2, b_prev;
    logic         [1:0] prev_ab;
    logic         [1:0] cur_ab;
    logic               step_fwd;
    logic               step_rev;
    logic               step_bad;
    logic signed [16:0] step;

    logic               en_q;
    logic               run;
    logic        [15:0] win_cnt;
    logic signed [15:0] acc;
    logic signed [16:0] acc_sum;
    logic signed [15:0] acc_next;
    logic signed [15:0] delta_q;
    logic               done_q;
    logic signed [12:0] delta_sat;
    logic signed [12:0] spd_next;

    logic        [15:0] pos;
    logic signed [12:0] spd;
    logic               valid;
    logic               err;

    // Synchroniser and history; history resets to 00 so the first non-00
    // level after reset decodes as a real transition.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            a_s1   <= 1'b0;
            a_s2   <= 1'b0;
            a_prev <= 1'b0;
            b_s1   <= 1'b0;
            b_s2   <= 1'b0;
            b_prev <= 1'b0;
        end else begin
            a_s1   <= bus.iEnc_A;
            a_s2   <= a_s1;
            a_prev <= a_s2;
            b_s1   <= bus.iEnc_B;
            b_s2   <= b_s1;
            b_prev <= b_s2;
        end
    end

    assign prev_ab = {a_prev, b_prev};
    assign cur_ab  = {a_s2, b_s2};

    // Forward sequence of {A,B}: 00 -> 01 -> 11 -> 10 -> 00
    always_comb begin
        step_fwd = 1'b0;
        step_rev = 1'b0;
        step_bad = 1'b0;
        case ({prev_ab, cur_ab})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step_fwd = 1'b1;
            4'b01_00, 4'b11_01, 4'b10_11, 4'b00_10: step_rev = 1'b1;
            4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: step_bad = 1'b1;
            default: ;
        endcase
    end

    assign step = step_fwd ? 17'sd1 : (step_rev ? -17'sd1 : 17'sd0);

    // The window only runs once iEn has been high for a full sampled cycle,
    // so the cycle after iEn is first seen high is window counter 0.
    assign run     = bus.iEn & en_q;
    assign acc_sum = $signed({acc[15], acc}) + step;

    always_comb begin
        if (acc_sum > 17'sd32767) begin
            acc_next = 16'sh7FFF;
        end else if (acc_sum < -17'sd32768) begin
            acc_next = 16'sh8000;
        end else begin
            acc_next = acc_sum[15:0];
        end
    end

    always_comb begin
        if (delta_q > 16'sd4095) begin
            delta_sat = 13'sd4095;
        end else if (delta_q < -16'sd4096) begin
            delta_sat = 13'sh1000;
        end else begin
            delta_sat = delta_q[12:0];
        end
    end

`ifdef ENCODER_SPEED_FILTER_EN
    logic signed [12:0] hist1, hist2, hist3;
    logic signed [14:0] filt_sum;

    assign filt_sum = $signed({{2{delta_sat[12]}}, delta_sat})
                    + $signed({{2{hist1[12]}}, hist1})
                    + $signed({{2{hist2[12]}}, hist2})
                    + $signed({{2{hist3[12]}}, hist3});
    assign spd_next = 13'(filt_sum >>> 2);

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            hist1 <= '0;
            hist2 <= '0;
            hist3 <= '0;
        end else if (!bus.iEn) begin
            hist1 <= '0;
            hist2 <= '0;
            hist3 <= '0;
        end else if (done_q) begin
            hist1 <= delta_sat;
            hist2 <= hist1;
            hist3 <= hist2;
        end
    end
`else
    assign spd_next = delta_sat;
`endif

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            pos <= '0;
        end else if (step_fwd) begin
            pos <= pos + 16'd1;
        end else if (step_rev) begin
            pos <= pos - 16'd1;
        end
    end

    // The terminal cycle's step is folded into delta_q and the accumulator
    // restarts at 0, so the following cycle's step opens the next window.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            en_q    <= 1'b0;
            win_cnt <= '0;
            acc     <= '0;
            delta_q <= '0;
            done_q  <= 1'b0;
        end else begin
            en_q <= bus.iEn;
            if (!run) begin
                win_cnt <= '0;
                acc     <= '0;
                done_q  <= 1'b0;
            end else if (win_cnt == LAST_CNT) begin
                win_cnt <= '0;
                acc     <= '0;
                delta_q <= acc_next;
                done_q  <= 1'b1;
            end else begin
                win_cnt <= win_cnt + 16'd1;
                acc     <= acc_next;
                done_q  <= 1'b0;
            end
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            spd   <= '0;
            valid <= 1'b0;
            err   <= 1'b0;
        end else begin
            valid <= done_q & bus.iEn;
            if (done_q && bus.iEn) begin
                spd <= spd_next;
            end
            if (!bus.iEn) begin
                err <= 1'b0;
            end else if (step_bad) begin
                err <= 1'b1;
            end
        end
    end

    assign bus.oSpd_coder = spd;
    assign bus.oSpd_valid = valid;
    assign bus.oPos       = pos;
    assign bus.oEnc_err   = err;

endmodule

// File: tb/tb_encoder_speed.sv
// tb_encoder_speed
// Bench for encoder_speed: a SAMPLE_DIV=100 instance checked every cycle
// against a behavioural model, plus a SAMPLE_DIV=10000 instance for the
// speed saturation case. Build with or without ENCODER_SPEED_FILTER_EN.
module tb_encoder_speed;

    localparam int unsigned SD  = 100;
    localparam int unsigned SD2 = 10000;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    encoder_speed_if bus1 ();
    encoder_speed_if bus2 ();

    encoder_speed #(.SAMPLE_DIV(SD)) dut (
        .iClk   (clk),
        .iRst_n (rst_n),
        .bus    (bus1)
    );

    encoder_speed #(.SAMPLE_DIV(SD2)) dut2 (
        .iClk   (clk),
        .iRst_n (rst_n),
        .bus    (bus2)
    );

    int checks = 0;
    int errors = 0;

    logic [1:0] gray [4];
    int g  = 0;
    int g2 = 0;

    // Behavioural model state
    int m_pos = 0, m_err = 0, m_spd = 0, m_vld = 0;
    int sh0 = 0, sh1 = 0, sh2 = 0;
    int runlen = 0, msum = 0, pend = 0, pend_edge = 0, pend_val = 0;
    int edge_n = 0;
    int fq[$];

    typedef struct {
        int period;
        int dir;
        int exp_spd;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Position of an {A,B} level within the forward gray cycle
    function automatic int gidx(input int ab);
        case (ab)
            0:       return 0;
            1:       return 1;
            3:       return 2;
            default: return 3;
        endcase
    endfunction

    // Per-cycle reference model and comparison for the SAMPLE_DIV=100 instance
    initial begin : model
        int s_rst, s_en, s_ab, stp, d, v, s;
        forever begin
            @(posedge clk);
            s_rst = int'(rst_n);
            s_en  = int'(bus1.iEn);
            s_ab  = 2 * int'(bus1.iEnc_A) + int'(bus1.iEnc_B);
            #1;
            edge_n++;
            if (s_rst == 0) begin
                m_pos = 0; m_err = 0; m_spd = 0; m_vld = 0;
                sh0 = 0; sh1 = 0; sh2 = 0;
                runlen = 0; msum = 0; pend = 0;
                fq.delete();
            end else begin
                d   = (gidx(sh1) - gidx(sh2) + 4) % 4;
                stp = (d == 1) ? 1 : ((d == 3) ? -1 : 0);
                sh2 = sh1; sh1 = sh0; sh0 = s_ab;
                m_pos = (m_pos + stp + 65536) % 65536;
                m_vld = 0;
                if (s_en == 0) begin
                    runlen = 0; msum = 0; pend = 0; m_err = 0;
                    fq.delete();
                end else begin
                    if (d == 2) m_err = 1;
                    if (pend == 1 && pend_edge == edge_n) begin
                        pend  = 0;
                        m_vld = 1;
                        v = (pend_val > 4095) ? 4095 : ((pend_val < -4096) ? -4096 : pend_val);
`ifdef ENCODER_SPEED_FILTER_EN
                        fq.push_back(v);
                        if (fq.size() > 4) void'(fq.pop_front());
                        s = 0;
                        foreach (fq[i]) s += fq[i];
                        m_spd = s >>> 2;
`else
                        s = v;
                        m_spd = s;
`endif
                    end
                    runlen++;
                    if (runlen >= 2) begin
                        msum += stp;
                        if ((runlen - 2) % SD == SD - 1) begin
                            pend = 1; pend_edge = edge_n + 1; pend_val = msum; msum = 0;
                        end
                    end
                end
            end
            check("model_pos",   int'(bus1.oPos),       m_pos);
            check("model_valid", int'(bus1.oSpd_valid), m_vld);
            check("model_err",   int'(bus1.oEnc_err),   m_err);
            check("model_spd",   int'(bus1.oSpd_coder), m_spd);
        end
    end

    task automatic drive_ab();
        logic [1:0] v;
        v = gray[g];
        bus1.iEnc_A = v[1];
        bus1.iEnc_B = v[0];
    endtask

    task automatic move(input int dir);
        g = (g + dir + 4) % 4;
        drive_ab();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Posedges until the next oSpd_valid, bounded; budget+1 on timeout
    task automatic edges_to_valid(input int budget, output int n);
        n = budget + 1;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk);
            #1;
            if (bus1.oSpd_valid) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic run_vec(input vec_t v);
        int nv, last_spd, last_cyc, last_pos;
        nv = 0; last_spd = 0; last_cyc = 0; last_pos = 0;
        idle(4);
        @(negedge clk) bus1.iEn = 1'b0;
        @(negedge clk) bus1.iEn = 1'b1;
        for (int i = 0; i < 5 * int'(SD) + 10; i++) begin
            @(negedge clk);
            if (i % v.period == 0) move(v.dir);
            if (bus1.oSpd_valid) begin
                if (nv > 0) begin
                    check("valid_interval", i - last_cyc, int'(SD));
                    check("pos_per_window", (int'(bus1.oPos) - last_pos + 65536) % 65536,
                          (v.exp_spd + 65536) % 65536);
                end
                nv++;
                last_spd = int'(bus1.oSpd_coder);
                last_cyc = i;
                last_pos = int'(bus1.oPos);
            end
        end
        check("windows_seen", nv, 5);
        check("vec_speed", last_spd, v.exp_spd);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int p0, n, r, nrec, found, spd2;
        int rec [4];
        int exp30 [4];
        logic [1:0] v2;

        gray[0] = 2'b00; gray[1] = 2'b01; gray[2] = 2'b11; gray[3] = 2'b10;
        vecs[0] = '{10,  1,  10};
        vecs[1] = '{ 5, -1, -20};
        vecs[2] = '{ 4,  1,  25};
        vecs[3] = '{25, -1,  -4};
        vecs[4] = '{ 1,  1, 100};
        vecs[5] = '{50,  1,   2};
`ifdef ENCODER_SPEED_FILTER_EN
        exp30[0] = 2; exp30[1] = 4; exp30[2] = 6; exp30[3] = 8;
`else
        exp30[0] = 8; exp30[1] = 8; exp30[2] = 8; exp30[3] = 8;
`endif

        rst_n = 1'b0;
        bus1.iEn = 1'b0; bus1.iEnc_A = 1'b0; bus1.iEnc_B = 1'b0;
        bus2.iEn = 1'b0; bus2.iEnc_A = 1'b0; bus2.iEnc_B = 1'b0;

        // Reset state
        idle(3);
        check("rst_pos",   int'(bus1.oPos),       0);
        check("rst_valid", int'(bus1.oSpd_valid), 0);
        check("rst_err",   int'(bus1.oEnc_err),   0);
        check("rst_spd",   int'(bus1.oSpd_coder), 0);
        rst_n = 1'b1;
        idle(4);

        // Reverse step from 0 wraps to 65535, visible on the 3rd edge
        @(negedge clk) move(-1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pos_latency2", int'(bus1.oPos), 0);
        @(posedge clk); #1;
        check("pos_wrap", int'(bus1.oPos), 65535);

        // Illegal 00 -> 11 sets the sticky error, iEn low clears it
        @(negedge clk) bus1.iEn = 1'b1;
        move(1);
        idle(6);
        p0 = int'(bus1.oPos);
        @(negedge clk) begin g = 2; drive_ab(); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("err_latency2", int'(bus1.oEnc_err), 0);
        @(posedge clk); #1;
        check("err_set", int'(bus1.oEnc_err), 1);
        check("err_pos_hold", int'(bus1.oPos), p0);
        idle(3);
        check("err_sticky", int'(bus1.oEnc_err), 1);
        @(negedge clk) bus1.iEn = 1'b0;
        @(posedge clk); #1;
        check("err_clear", int'(bus1.oEnc_err), 0);

        // First strobe after enable rise
        @(negedge clk) bus1.iEn = 1'b1;
        edges_to_valid(200, n);
        check("first_valid_latency", n, int'(SD) + 2);

        // Reset in mid-window drops the partial window
        repeat (50) @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_pos",   int'(bus1.oPos),       0);
        check("midrst_valid", int'(bus1.oSpd_valid), 0);
        check("midrst_err",   int'(bus1.oEnc_err),   0);
        check("midrst_spd",   int'(bus1.oSpd_coder), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        edges_to_valid(200, n);
        check("post_reset_valid_latency", n, int'(SD) + 2);

        // Constant-rate vectors
        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Rate step from 0 to 8 counts per window
        idle(6);
        @(negedge clk) bus1.iEn = 1'b0;
        @(negedge clk) bus1.iEn = 1'b1;
        nrec = 0;
        for (int c = 0; c < 4 * int'(SD) + 6; c++) begin
            @(posedge clk); #1;
            if (bus1.oSpd_valid && nrec < 4) begin
                rec[nrec] = int'(bus1.oSpd_coder);
                nrec++;
            end
            @(negedge clk);
            if ((c % SD) >= 10 && (c % SD) <= 80 && (c % 10) == 0) move(1);
        end
        check("step8_windows", nrec, 4);
        for (int i = 0; i < 4; i++) check("step8_speed", rec[i], exp30[i]);

        // Randomised stimulus, checked by the model
        @(negedge clk) bus1.iEn = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            r = $urandom_range(0, 999);
            if (r < 350) move(1);
            else if (r < 550) move(-1);
            else if (r < 565) move(2);
            else if (r < 568) bus1.iEn = ~bus1.iEn;
            if (!bus1.iEn && r >= 900) bus1.iEn = 1'b1;
        end

        // Saturation on the SAMPLE_DIV=10000 instance
        @(negedge clk) bus2.iEn = 1'b1;
        found = 0; spd2 = 0;
        for (int i = 0; i < int'(SD2) + 200; i++) begin
            @(negedge clk);
            if (i % 2 == 0) begin
                g2 = (g2 + 1) % 4;
                v2 = gray[g2];
                bus2.iEnc_A = v2[1];
                bus2.iEnc_B = v2[0];
            end
            if (bus2.oSpd_valid) begin
                found = 1;
                spd2 = int'(bus2.oSpd_coder);
                break;
            end
        end
        check("sat_window_seen", found, 1);
`ifdef ENCODER_SPEED_FILTER_EN
        check("sat_speed", spd2, 1023);
`else
        check("sat_speed", spd2, 4095);
`endif

        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
